// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
// One request at a time; the response carries load data or a write acknowledge.
interface mem_access_if #(
  parameter int XLEN = 64
);
  logic            dmem_req_valid;
  logic            dmem_req_ready;
  logic [XLEN-1:0] dmem_addr;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wmask;
  logic            dmem_rsp_valid;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wmask,
    input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );

  modport slave (
    input  dmem_req_valid, dmem_addr, dmem_we, dmem_wdata, dmem_wmask,
    output dmem_req_ready, dmem_rsp_valid, dmem_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: one instruction in flight, issues a single data-memory
// request for loads/stores, aligns/extends load data, and hands the result to write-back.
module mem_access #(
  parameter int XLEN          = 64,
  parameter int REG_ADDRWIDTH = 5,
  parameter int MEMOP_LEN     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [XLEN-1:0]          ex_result,
  input  logic [XLEN-1:0]          ex_rs2_data,
  input  logic [REG_ADDRWIDTH-1:0] ex_rd_idx,
  input  logic                     ex_rd_we,
  input  logic [MEMOP_LEN-1:0]     ex_mem_op,
  mem_access_if.master             dmem,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [REG_ADDRWIDTH-1:0] wb_rd_idx,
  output logic                     wb_rd_we,
  output logic [XLEN-1:0]          wb_data,
  output logic                     wb_misalign
);
  localparam logic [MEMOP_LEN-1:0] MEMOP_NONE = MEMOP_LEN'(0);
  localparam logic [MEMOP_LEN-1:0] LB  = MEMOP_LEN'(1);
  localparam logic [MEMOP_LEN-1:0] LBU = MEMOP_LEN'(2);
  localparam logic [MEMOP_LEN-1:0] LH  = MEMOP_LEN'(3);
  localparam logic [MEMOP_LEN-1:0] LHU = MEMOP_LEN'(4);
  localparam logic [MEMOP_LEN-1:0] LW  = MEMOP_LEN'(5);
  localparam logic [MEMOP_LEN-1:0] LWU = MEMOP_LEN'(6);
  localparam logic [MEMOP_LEN-1:0] LD  = MEMOP_LEN'(7);
  localparam logic [MEMOP_LEN-1:0] SB  = MEMOP_LEN'(8);
  localparam logic [MEMOP_LEN-1:0] SH  = MEMOP_LEN'(9);
  localparam logic [MEMOP_LEN-1:0] SW  = MEMOP_LEN'(10);
  localparam logic [MEMOP_LEN-1:0] SD  = MEMOP_LEN'(11);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic [MEMOP_LEN-1:0] op;
    logic [2:0]           ofs;
    logic                 rd_we;
  } inst_t;

  state_t state;
  inst_t  inst_q;

  assign ex_ready = (state == IDLE);

  // Decode of the incoming op: access size as log2 bytes.
  logic       dec_load, dec_store, dec_mis;
  logic [1:0] dec_size;
  logic [2:0] dec_ofs;
  logic [7:0] dec_mask;

  assign dec_ofs = ex_result[2:0];

  always_comb begin
    dec_load  = 1'b0;
    dec_store = 1'b0;
    dec_size  = 2'd0;
    case (ex_mem_op)
      LB, LBU: begin dec_load  = 1'b1; dec_size = 2'd0; end
      LH, LHU: begin dec_load  = 1'b1; dec_size = 2'd1; end
      LW, LWU: begin dec_load  = 1'b1; dec_size = 2'd2; end
      LD:      begin dec_load  = 1'b1; dec_size = 2'd3; end
      SB:      begin dec_store = 1'b1; dec_size = 2'd0; end
      SH:      begin dec_store = 1'b1; dec_size = 2'd1; end
      SW:      begin dec_store = 1'b1; dec_size = 2'd2; end
      SD:      begin dec_store = 1'b1; dec_size = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    dec_mis  = 1'b0;
    dec_mask = 8'h01;
    case (dec_size)
      2'd0: begin dec_mis = 1'b0;          dec_mask = 8'h01; end
      2'd1: begin dec_mis = dec_ofs[0];    dec_mask = 8'h03; end
      2'd2: begin dec_mis = |dec_ofs[1:0]; dec_mask = 8'h0F; end
      2'd3: begin dec_mis = |dec_ofs;      dec_mask = 8'hFF; end
      default: ;
    endcase
  end

  // Load alignment: bring the addressed byte lane down to bit 0, then extend.
  logic [XLEN-1:0] ld_sh, ld_data;
  logic            q_load;

  assign ld_sh  = dmem.dmem_rdata >> {inst_q.ofs, 3'b000};
  assign q_load = (inst_q.op >= LB) && (inst_q.op <= LD);

  always_comb begin
    ld_data = ld_sh;
    case (inst_q.op)
      LB:      ld_data = {{(XLEN-8){ld_sh[7]}},   ld_sh[7:0]};
      LBU:     ld_data = {{(XLEN-8){1'b0}},       ld_sh[7:0]};
      LH:      ld_data = {{(XLEN-16){ld_sh[15]}}, ld_sh[15:0]};
      LHU:     ld_data = {{(XLEN-16){1'b0}},      ld_sh[15:0]};
      LW:      ld_data = {{(XLEN-32){ld_sh[31]}}, ld_sh[31:0]};
      LWU:     ld_data = {{(XLEN-32){1'b0}},      ld_sh[31:0]};
      default: ld_data = ld_sh;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      inst_q              <= '0;
      dmem.dmem_req_valid <= 1'b0;
      dmem.dmem_addr      <= '0;
      dmem.dmem_we        <= 1'b0;
      dmem.dmem_wdata     <= '0;
      dmem.dmem_wmask     <= '0;
      wb_valid            <= 1'b0;
      wb_rd_idx           <= '0;
      wb_rd_we            <= 1'b0;
      wb_data             <= '0;
      wb_misalign         <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ex_valid) begin
          inst_q    <= '{op: ex_mem_op, ofs: dec_ofs, rd_we: ex_rd_we};
          wb_rd_idx <= ex_rd_idx;
          if (!(dec_load || dec_store)) begin
            state       <= DONE;
            wb_valid    <= 1'b1;
            wb_data     <= ex_result;
            wb_rd_we    <= ex_rd_we && (ex_rd_idx != '0);
            wb_misalign <= 1'b0;
          end else if (dec_mis) begin
            // Suppressed access: result still retires so the fault is visible downstream.
            state       <= DONE;
            wb_valid    <= 1'b1;
            wb_data     <= ex_result;
            wb_rd_we    <= 1'b0;
            wb_misalign <= 1'b1;
          end else begin
            state               <= REQ;
            dmem.dmem_req_valid <= 1'b1;
            dmem.dmem_addr      <= {ex_result[XLEN-1:3], 3'b000};
            dmem.dmem_we        <= dec_store;
            dmem.dmem_wdata     <= dec_store ? (ex_rs2_data << {dec_ofs, 3'b000}) : '0;
            dmem.dmem_wmask     <= dec_store ? (dec_mask << dec_ofs) : 8'h00;
          end
        end
        REQ: if (dmem.dmem_req_ready) begin
          state               <= WAIT;
          dmem.dmem_req_valid <= 1'b0;
        end
        WAIT: if (dmem.dmem_rsp_valid) begin
          state       <= DONE;
          wb_valid    <= 1'b1;
          wb_misalign <= 1'b0;
          wb_data     <= q_load ? ld_data : '0;
          wb_rd_we    <= q_load && inst_q.rd_we && (wb_rd_idx != '0);
        end
        DONE: if (wb_ready) begin
          state    <= IDLE;
          wb_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
